// File: rtl/axi4_mgr_pkg.sv
// Shared types for the AXI4 manager job arbiter: FSM states, direction bit
// indices into the two-bit manager req/done vectors, and the stored job record.
// Holds no logic of its own.
package axi4_mgr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Bit positions inside mgr_req_o / mgr_done_i.
    localparam int DIR_WR = 0;
    localparam int DIR_RD = 1;

    // The job record is sized for the widest supported instance; each
    // instance zero-extends its own address/count into it and slices back out.
    localparam int JOB_ADDR_MAX_W  = 64;
    localparam int JOB_COUNT_MAX_W = 32;

    typedef struct packed {
        logic                       we;
        logic [JOB_ADDR_MAX_W-1:0]  addr;
        logic [JOB_COUNT_MAX_W-1:0] count;
    } job_t;

    // One-hot manager request vector for a job direction.
    function automatic logic [1:0] dir_mask(input logic we);
        logic [1:0] m;
        m = 2'b00;
        if (we) begin
            m[DIR_WR] = 1'b1;
        end else begin
            m[DIR_RD] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant: first asserted request at or after ptr_i+1 (wrapping).
// Latency: purely combinational, grant valid in the same cycle as the request.
// Backpressure: none; the caller decides whether the grant is consumed.
// Ports: req_i request vector, ptr_i index of last winner, gnt_o one-hot grant.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [PTR_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o
);

    logic             found;
    logic [PTR_W-1:0] idx;

    // Walk the requesters starting just after the last winner so the
    // previous owner is considered last.
    always_comb begin
        gnt_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PTR_W'((int'(ptr_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi4_mgr_arb.sv
// Serialises per-requester read/write jobs onto one AXI4 manager job port.
// Latency: grant->mgr_req 1 cycle, mgr_done->done_o 1 cycle, zero-count job done 1 cycle after grant.
// Backpressure: job_ready_o only in IDLE; one job in flight, watchdog-timed jobs drain the late done.
// Ports: job_* requester side (valid/ready, we/addr/count), done_* completion back to owner,
//        mgr_* manager side (one-cycle req, held addr/count, done pulse + latched err), busy_o.
module axi4_mgr_arb
    import axi4_mgr_pkg::*;
#(
    parameter int NUM_REQ          = 4,
    parameter int AXI_ADDR_WIDTH   = 32,
    parameter int DATA_COUNT_WIDTH = 8,
    parameter int TIMEOUT_CYCLES   = 1024
) (
    input  logic                                          clk_i,
    input  logic                                          rstn_i,
    input  logic [NUM_REQ-1:0]                            job_valid_i,
    output logic [NUM_REQ-1:0]                            job_ready_o,
    input  logic [NUM_REQ-1:0]                            job_we_i,
    input  logic [NUM_REQ-1:0][AXI_ADDR_WIDTH-1:0]        job_addr_i,
    input  logic [NUM_REQ-1:0][DATA_COUNT_WIDTH-1:0]      job_count_i,
    output logic [NUM_REQ-1:0]                            done_o,
    output logic [1:0]                                    done_err_o,
    output logic                                          done_timeout_o,
    output logic [1:0]                                    mgr_req_o,
    output logic [AXI_ADDR_WIDTH-1:0]                     mgr_wr_addr_o,
    output logic [AXI_ADDR_WIDTH-1:0]                     mgr_rd_addr_o,
    output logic [DATA_COUNT_WIDTH-1:0]                   mgr_wr_count_o,
    output logic [DATA_COUNT_WIDTH-1:0]                   mgr_rd_count_o,
    input  logic [1:0]                                    mgr_done_i,
    input  logic [1:0]                                    mgr_wr_err_i,
    input  logic [1:0]                                    mgr_rd_err_i,
    output logic                                          busy_o
);

    localparam int PW  = $clog2(NUM_REQ);
    localparam int WDW = $clog2(TIMEOUT_CYCLES);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT_CYCLES - 1);

    state_e               state_q;
    logic [PW-1:0]        ptr_q;
    job_t                 job_q;
    job_t                 job_d;
    logic [NUM_REQ-1:0]   grant_q;
    logic [WDW-1:0]       wdog_q;
    logic [1:0]           mgr_req_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [1:0]           done_err_q;
    logic                 done_to_q;

    logic [NUM_REQ-1:0]   arb_gnt;
    logic [PW-1:0]        gnt_idx;
    logic                 act_done;
    logic [1:0]           act_err;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PW)
    ) u_arb (
        .req_i   (job_valid_i),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt)
    );

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                gnt_idx = PW'(i);
            end
        end
    end

    // Job fields of the requester that would win this cycle.
    always_comb begin
        job_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (arb_gnt[i]) begin
                job_d.we    = job_we_i[i];
                job_d.addr  = JOB_ADDR_MAX_W'(job_addr_i[i]);
                job_d.count = JOB_COUNT_MAX_W'(job_count_i[i]);
            end
        end
    end

    // Only the active direction's done/err matter; the other pair is ignored.
    assign act_done = job_q.we ? mgr_done_i[DIR_WR] : mgr_done_i[DIR_RD];
    assign act_err  = job_q.we ? mgr_wr_err_i       : mgr_rd_err_i;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q    <= ST_IDLE;
            ptr_q      <= PW'(NUM_REQ - 1);
            job_q      <= '0;
            grant_q    <= '0;
            wdog_q     <= '0;
            mgr_req_q  <= '0;
            done_q     <= '0;
            done_err_q <= '0;
            done_to_q  <= 1'b0;
        end else begin
            // Pulse outputs default low; each state raises them for one cycle.
            mgr_req_q  <= '0;
            done_q     <= '0;
            done_err_q <= '0;
            done_to_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (|arb_gnt) begin
                        job_q   <= job_d;
                        grant_q <= arb_gnt;
                        ptr_q   <= gnt_idx;
                        if (job_d.count == '0) begin
                            // Nothing to move: complete without touching the manager.
                            state_q <= ST_RESP;
                            done_q  <= arb_gnt;
                        end else begin
                            state_q   <= ST_ISSUE;
                            mgr_req_q <= dir_mask(job_d.we);
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
                    wdog_q  <= '0;
                end
                ST_WAIT: begin
                    if (act_done) begin
                        state_q    <= ST_RESP;
                        done_q     <= grant_q;
                        done_err_q <= act_err;
                    end else if (wdog_q == WD_LAST) begin
                        state_q    <= ST_RESP;
                        done_q     <= grant_q;
                        done_err_q <= 2'b10;
                        done_to_q  <= 1'b1;
                    end else begin
                        wdog_q <= wdog_q + 1'b1;
                    end
                end
                ST_RESP: begin
                    // A timed-out job still owes a manager done; drain it unless
                    // it lands in this very cycle, which would otherwise be lost.
                    if (done_to_q && !act_done) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (act_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // The stored record is wider than this instance's fields; the upper bits
    // are always zero and fold away.
    if (AXI_ADDR_WIDTH < JOB_ADDR_MAX_W) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^job_q.addr[JOB_ADDR_MAX_W-1:AXI_ADDR_WIDTH];
    end
    if (DATA_COUNT_WIDTH < JOB_COUNT_MAX_W) begin : g_count_hi
        logic unused_count_hi;
        assign unused_count_hi = ^job_q.count[JOB_COUNT_MAX_W-1:DATA_COUNT_WIDTH];
    end

    assign job_ready_o    = (state_q == ST_IDLE) ? arb_gnt : '0;
    assign done_o         = done_q;
    assign done_err_o     = done_err_q;
    assign done_timeout_o = done_to_q;
    assign mgr_req_o      = mgr_req_q;
    assign mgr_wr_addr_o  = job_q.addr[AXI_ADDR_WIDTH-1:0];
    assign mgr_rd_addr_o  = job_q.addr[AXI_ADDR_WIDTH-1:0];
    assign mgr_wr_count_o = job_q.count[DATA_COUNT_WIDTH-1:0];
    assign mgr_rd_count_o = job_q.count[DATA_COUNT_WIDTH-1:0];
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi4_mgr_arb.sv
// Scoreboard bench for axi4_mgr_arb: directed jobs push expected grant/issue/done
// records; a negedge monitor pops and compares whenever the DUT presents one.
// A small manager model answers issued jobs after a configurable latency.
module tb_axi4_mgr_arb;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int CW = 8;
    localparam int TO = 16;

    logic                  clk_i = 1'b0;
    logic                  rstn_i;
    logic [N-1:0]          job_valid_i;
    logic [N-1:0]          job_ready_o;
    logic [N-1:0]          job_we_i;
    logic [N-1:0][AW-1:0]  job_addr_i;
    logic [N-1:0][CW-1:0]  job_count_i;
    logic [N-1:0]          done_o;
    logic [1:0]            done_err_o;
    logic                  done_timeout_o;
    logic [1:0]            mgr_req_o;
    logic [AW-1:0]         mgr_wr_addr_o;
    logic [AW-1:0]         mgr_rd_addr_o;
    logic [CW-1:0]         mgr_wr_count_o;
    logic [CW-1:0]         mgr_rd_count_o;
    logic [1:0]            mgr_done_i;
    logic [1:0]            mgr_wr_err_i;
    logic [1:0]            mgr_rd_err_i;
    logic                  busy_o;

    axi4_mgr_arb #(
        .NUM_REQ          (N),
        .AXI_ADDR_WIDTH   (AW),
        .DATA_COUNT_WIDTH (CW),
        .TIMEOUT_CYCLES   (TO)
    ) dut (
        .clk_i          (clk_i),
        .rstn_i         (rstn_i),
        .job_valid_i    (job_valid_i),
        .job_ready_o    (job_ready_o),
        .job_we_i       (job_we_i),
        .job_addr_i     (job_addr_i),
        .job_count_i    (job_count_i),
        .done_o         (done_o),
        .done_err_o     (done_err_o),
        .done_timeout_o (done_timeout_o),
        .mgr_req_o      (mgr_req_o),
        .mgr_wr_addr_o  (mgr_wr_addr_o),
        .mgr_rd_addr_o  (mgr_rd_addr_o),
        .mgr_wr_count_o (mgr_wr_count_o),
        .mgr_rd_count_o (mgr_rd_count_o),
        .mgr_done_i     (mgr_done_i),
        .mgr_wr_err_i   (mgr_wr_err_i),
        .mgr_rd_err_i   (mgr_rd_err_i),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [1:0]    req;
        logic [AW-1:0] addr;
        logic [CW-1:0] cnt;
    } iss_t;

    typedef struct {
        logic [N-1:0] done;
        logic [1:0]   err;
        logic         to;
    } dn_t;

    int   exp_grant[$];
    iss_t exp_iss[$];
    dn_t  exp_dn[$];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int grant_cnt = 0, issue_cnt = 0, done_cnt = 0;
    int last_grant_cyc = 0, last_issue_cyc = 0, last_done_cyc = 0;

    logic       mgr_auto;
    int         mgr_lat;
    logic [1:0] pulse_bits;
    int         pulse_seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic miss(input string name);
        checks++;
        fails++;
        $display("FAIL %s: event with no expected entry", name);
    endtask

    always @(posedge clk_i) cyc <= cyc + 1;

    // Monitor: compares every presented grant / manager issue / done against the queues.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rstn_i) begin
                if (job_ready_o != '0) begin
                    if (exp_grant.size() == 0) begin
                        miss("grant");
                    end else begin
                        int g;
                        g = exp_grant.pop_front();
                        chk("grant_onehot", job_ready_o, 64'(1) << g);
                        chk("grant_in_idle", busy_o, 0);
                    end
                    grant_cnt++;
                    last_grant_cyc = cyc;
                end
                if (mgr_req_o != 2'b00) begin
                    if (exp_iss.size() == 0) begin
                        miss("mgr_req");
                    end else begin
                        iss_t e;
                        e = exp_iss.pop_front();
                        chk("mgr_req", mgr_req_o, e.req);
                        chk("mgr_addr", e.req[0] ? mgr_wr_addr_o : mgr_rd_addr_o, e.addr);
                        chk("mgr_count", e.req[0] ? mgr_wr_count_o : mgr_rd_count_o, e.cnt);
                    end
                    issue_cnt++;
                    last_issue_cyc = cyc;
                end
                if (done_o != '0) begin
                    if (exp_dn.size() == 0) begin
                        miss("done");
                    end else begin
                        dn_t d;
                        d = exp_dn.pop_front();
                        chk("done_vec", done_o, d.done);
                        chk("done_err", done_err_o, d.err);
                        chk("done_timeout", done_timeout_o, d.to);
                    end
                    done_cnt++;
                    last_done_cyc = cyc;
                end else begin
                    chk("err_to_quiet", {done_err_o, done_timeout_o}, 0);
                end
            end
        end
    end

    // Manager model: sole driver of mgr_done_i.
    initial begin
        int seen;
        logic [1:0] bits;
        seen = 0;
        mgr_done_i = 2'b00;
        forever begin
            @(negedge clk_i);
            if (pulse_seq != seen) begin
                seen = pulse_seq;
                @(posedge clk_i); #1;
                mgr_done_i = pulse_bits;
                @(posedge clk_i); #1;
                mgr_done_i = 2'b00;
            end else if (mgr_auto && mgr_req_o != 2'b00) begin
                bits = mgr_req_o;
                repeat (mgr_lat) @(posedge clk_i);
                #1;
                mgr_done_i = bits;
                @(posedge clk_i); #1;
                mgr_done_i = 2'b00;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // which: 0 grants, 1 issues, 2 dones
    task automatic wait_until(input string name, input int which, input int target);
        int cur;
        for (int n = 0; n < 300; n++) begin
            cur = (which == 0) ? grant_cnt : (which == 1) ? issue_cnt : done_cnt;
            if (cur >= target) return;
            tick();
        end
        checks++;
        fails++;
        $display("FAIL %s: wait expired, got %0d events, required %0d", name, cur, target);
    endtask

    task automatic add_job(input int r, input logic we, input logic [AW-1:0] addr,
                           input logic [CW-1:0] cnt, input logic [1:0] err,
                           input logic to, input bit want_done);
        iss_t e;
        dn_t  d;
        job_we_i[r]    = we;
        job_addr_i[r]  = addr;
        job_count_i[r] = cnt;
        exp_grant.push_back(r);
        if (cnt != '0) begin
            e.req  = we ? 2'b01 : 2'b10;
            e.addr = addr;
            e.cnt  = cnt;
            exp_iss.push_back(e);
        end
        if (want_done) begin
            d.done = N'(1) << r;
            d.err  = err;
            d.to   = to;
            exp_dn.push_back(d);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ready"}, job_ready_o, 0);
        chk({tag, "_done"}, done_o, 0);
        chk({tag, "_err"}, done_err_o, 0);
        chk({tag, "_to"}, done_timeout_o, 0);
        chk({tag, "_mgr_req"}, mgr_req_o, 0);
        chk({tag, "_wr_addr"}, mgr_wr_addr_o, 0);
        chk({tag, "_rd_addr"}, mgr_rd_addr_o, 0);
        chk({tag, "_wr_cnt"}, mgr_wr_count_o, 0);
        chk({tag, "_rd_cnt"}, mgr_rd_count_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        int g0, i0, d0;
        rstn_i       = 1'b0;
        job_valid_i  = '0;
        job_we_i     = '0;
        job_addr_i   = '0;
        job_count_i  = '0;
        mgr_wr_err_i = 2'b00;
        mgr_rd_err_i = 2'b00;
        mgr_auto     = 1'b0;
        mgr_lat      = 1;
        pulse_bits   = 2'b00;

        @(negedge clk_i);
        chk_all_zero("reset");
        tick(); tick();
        rstn_i = 1'b1;
        tick();

        // All four requesting continuously: 0,1,2,3 then wrap to 0.
        mgr_auto = 1'b1;
        mgr_lat  = 1;
        for (int i = 0; i < N; i++)
            add_job(i, (i % 2) == 0, AW'(32'h100 * (i + 1)), CW'(i + 1), 2'b00, 1'b0, 1);
        add_job(0, 1'b1, 32'h100, 8'd1, 2'b00, 1'b0, 1);
        g0 = grant_cnt; d0 = done_cnt;
        job_valid_i = 4'hF;
        wait_until("rr_grants", 0, g0 + 5);
        job_valid_i = '0;
        wait_until("rr_dones", 2, d0 + 5);

        // Single write job, manager answers two cycles after the req pulse.
        tick();
        mgr_lat = 2;
        add_job(0, 1'b1, 32'h1000, 8'd4, 2'b00, 1'b0, 1);
        g0 = grant_cnt; d0 = done_cnt;
        job_valid_i = 4'b0001;
        wait_until("wr_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("wr_done", 2, d0 + 1);
        chk("wr_grant_to_issue", last_issue_cyc - last_grant_cyc, 1);
        chk("wr_issue_to_done", last_done_cyc - last_issue_cyc, 3);
        chk("wr_addr_held", mgr_wr_addr_o, 32'h1000);
        chk("wr_cnt_held", mgr_wr_count_o, 4);

        // Zero-count read from requester 2: no manager traffic.
        tick();
        add_job(2, 1'b0, 32'h2222, 8'd0, 2'b00, 1'b0, 1);
        g0 = grant_cnt; d0 = done_cnt; i0 = issue_cnt;
        job_valid_i = 4'b0100;
        wait_until("zc_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("zc_done", 2, d0 + 1);
        chk("zc_latency_le3", (last_done_cyc - last_grant_cyc) <= 3, 1);
        chk("zc_no_mgr_req", issue_cnt, i0);

        // Read job with a slave error; the write error input must not leak through.
        tick();
        mgr_lat      = 1;
        mgr_rd_err_i = 2'b11;
        mgr_wr_err_i = 2'b01;
        add_job(1, 1'b0, 32'h2000, 8'd8, 2'b11, 1'b0, 1);
        g0 = grant_cnt; d0 = done_cnt;
        job_valid_i = 4'b0010;
        wait_until("rd_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("rd_done", 2, d0 + 1);
        chk("rd_addr_held", mgr_rd_addr_o, 32'h2000);
        chk("rd_cnt_held", mgr_rd_count_o, 8);
        mgr_rd_err_i = 2'b00;
        mgr_wr_err_i = 2'b00;

        // Watchdog: read job never answered (a stray write done is ignored).
        tick();
        mgr_auto = 1'b0;
        add_job(3, 1'b0, 32'h3000, 8'd2, 2'b10, 1'b1, 1);
        g0 = grant_cnt; d0 = done_cnt; i0 = issue_cnt;
        job_valid_i = 4'b1000;
        wait_until("to_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("to_issue", 1, i0 + 1);
        repeat (3) tick();
        pulse_bits = 2'b01;
        pulse_seq++;
        wait_until("to_done", 2, d0 + 1);
        chk("to_issue_to_done", last_done_cyc - last_issue_cyc, TO + 1);
        add_job(0, 1'b1, 32'h4000, 8'd1, 2'b00, 1'b0, 1);
        job_valid_i = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("drain_busy", busy_o, 1);
            chk("drain_no_ready", job_ready_o, 0);
        end
        tick();
        g0 = grant_cnt; d0 = done_cnt;
        mgr_auto   = 1'b1;
        mgr_lat    = 1;
        pulse_bits = 2'b10;
        pulse_seq++;
        wait_until("post_drain_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("post_drain_done", 2, d0 + 1);

        // Reset while waiting on the manager: job abandoned silently.
        tick();
        mgr_auto = 1'b0;
        add_job(1, 1'b1, 32'h5000, 8'd3, 2'b00, 1'b0, 0);
        g0 = grant_cnt; i0 = issue_cnt;
        job_valid_i = 4'b0010;
        wait_until("rst_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("rst_issue", 1, i0 + 1);
        tick();
        tick();
        d0 = done_cnt;
        rstn_i = 1'b0;
        @(negedge clk_i);
        chk_all_zero("midrst");
        tick();
        rstn_i = 1'b1;
        tick(); tick();
        chk("midrst_no_done", done_cnt, d0);
        mgr_auto = 1'b1;
        add_job(0, 1'b0, 32'h6000, 8'd1, 2'b00, 1'b0, 1);
        g0 = grant_cnt; d0 = done_cnt;
        job_valid_i = 4'hF;
        wait_until("post_rst_grant", 0, g0 + 1);
        job_valid_i = '0;
        wait_until("post_rst_done", 2, d0 + 1);
        tick(); tick();

        chk("left_grants", exp_grant.size(), 0);
        chk("left_issues", exp_iss.size(), 0);
        chk("left_dones", exp_dn.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
